// File: rtl/switch_matrix_cfg_if.sv
// ============================================================================
//  Module   : switch_matrix_cfg_if
//  Brief    : Configuration load/commit port bundle for switch_matrix_cfg.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface switch_matrix_cfg_if #(
    parameter int NTB  = 5,
    parameter int NLR  = 4,
    parameter int IDXW = 3
);
    localparam int c_EW = IDXW + 3;
    localparam int c_NW = 2 * NTB + 2 * NLR;
    localparam int c_CW = $clog2(c_NW + 1);

    logic            cfg_start;
    logic            cfg_valid;
    logic [c_EW-1:0] cfg_word;
    logic            cfg_ready;
    logic            cfg_commit;
    logic            cfg_abort;
    logic            cfg_busy;
    logic [c_CW-1:0] cfg_count;
    logic            cfg_err;
    logic            cfg_done;

    modport master (
        output cfg_start, cfg_valid, cfg_word, cfg_commit, cfg_abort,
        input  cfg_ready, cfg_busy, cfg_count, cfg_err, cfg_done
    );

    modport slave (
        input  cfg_start, cfg_valid, cfg_word, cfg_commit, cfg_abort,
        output cfg_ready, cfg_busy, cfg_count, cfg_err, cfg_done
    );
endinterface

`default_nettype wire

// File: rtl/switch_matrix_cfg.sv
// ============================================================================
//  Module   : switch_matrix_cfg
//  Brief    : Runtime-configurable routing switch box with shadow/active
//             entry stores and atomic commit.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module switch_matrix_cfg #(
    parameter int NTB  = 5,
    parameter int NLR  = 4,
    parameter int IDXW = 3
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    inout  wire [NTB-1:0] wtop,
    inout  wire [NTB-1:0] wbottom,
    inout  wire [NLR-1:0] wleft,
    inout  wire [NLR-1:0] wright,
    switch_matrix_cfg_if.slave cfg
);
    localparam int c_EW   = IDXW + 3;
    localparam int c_NW   = 2 * NTB + 2 * NLR;
    localparam int c_CW   = $clog2(c_NW + 1);
    localparam int c_SPAN = 1 << IDXW;

    localparam logic [2:0] c_NONE   = 3'd0;
    localparam logic [2:0] c_TOP    = 3'd1;
    localparam logic [2:0] c_RIGHT  = 3'd2;
    localparam logic [2:0] c_BOTTOM = 3'd3;
    localparam logic [2:0] c_LEFT   = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_FULL = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [c_CW-1:0] r_count;
    logic            r_err;
    logic            r_done;
    logic [c_EW-1:0] r_shadow [c_NW];
    logic [c_EW-1:0] r_active [c_NW];

    logic            w_clear;
    logic            w_accept;
    logic            w_commit_ok;
    logic            w_word_bad;

    // Entry position -> side code / index of the wire it drives.
    function automatic logic [2:0] dest_side(input int pos);
        if (pos < NTB)                 return c_TOP;
        else if (pos < NTB + NLR)      return c_RIGHT;
        else if (pos < 2 * NTB + NLR)  return c_BOTTOM;
        else                           return c_LEFT;
    endfunction

    function automatic logic [IDXW-1:0] dest_idx(input int pos);
        if (pos < NTB)                 return IDXW'(pos);
        else if (pos < NTB + NLR)      return IDXW'(pos - NTB);
        else if (pos < 2 * NTB + NLR)  return IDXW'(pos - NTB - NLR);
        else                           return IDXW'(pos - 2 * NTB - NLR);
    endfunction

    // Code 0 is a legal "undriven" entry; everything else must be in range
    // and must not point back at the wire it drives.
    function automatic logic entry_bad(input logic [c_EW-1:0] e, input int pos);
        logic [2:0]      side;
        logic [IDXW-1:0] idx;
        int              width;
        side = e[2:0];
        idx  = e[c_EW-1:3];
        case (side)
            c_TOP, c_BOTTOM: width = NTB;
            c_RIGHT, c_LEFT: width = NLR;
            default:         width = 0;
        endcase
        if (side == c_NONE)       return 1'b0;
        if (side > c_LEFT)        return 1'b1;
        if (int'(idx) >= width)   return 1'b1;
        return (side == dest_side(pos)) && (idx == dest_idx(pos));
    endfunction

    assign w_word_bad = entry_bad(cfg.cfg_word, int'(r_count));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_clear      = 1'b0;
        w_accept     = 1'b0;
        w_commit_ok  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!cfg.cfg_abort && cfg.cfg_start) begin
                    w_state_next = S_LOAD;
                    w_clear      = 1'b1;
                end
            end
            S_LOAD: begin
                if (cfg.cfg_abort) begin
                    w_state_next = S_IDLE;
                end else if (cfg.cfg_start) begin
                    w_clear = 1'b1;
                end else if (cfg.cfg_valid) begin
                    w_accept = 1'b1;
                    if (r_count == c_CW'(c_NW - 1)) w_state_next = S_FULL;
                end
            end
            S_FULL: begin
                if (cfg.cfg_abort) begin
                    w_state_next = S_IDLE;
                end else if (cfg.cfg_start) begin
                    w_state_next = S_LOAD;
                    w_clear      = 1'b1;
                end else if (cfg.cfg_commit) begin
                    w_state_next = S_IDLE;
                    w_commit_ok  = !r_err;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_err   <= 1'b0;
            r_done  <= 1'b0;
            for (int i = 0; i < c_NW; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
        end else begin
            r_done <= w_commit_ok;
            if (w_clear) begin
                r_count <= '0;
                r_err   <= 1'b0;
            end else if (w_accept) begin
                r_count <= r_count + c_CW'(1);
                if (w_word_bad) r_err <= 1'b1;
            end
            for (int i = 0; i < c_NW; i++) begin
                if (w_accept && (c_CW'(i) == r_count)) r_shadow[i] <= cfg.cfg_word;
            end
            if (w_commit_ok) begin
                for (int i = 0; i < c_NW; i++) r_active[i] <= r_shadow[i];
            end
        end
    end

    assign cfg.cfg_ready = (r_state == S_LOAD);
    assign cfg.cfg_busy  = (r_state != S_IDLE);
    assign cfg.cfg_count = r_count;
    assign cfg.cfg_err   = r_err;
    assign cfg.cfg_done  = r_done;

    // Sides widened to a full index span so any IDXW-bit index is a legal select.
    logic [c_SPAN-1:0] w_top_x, w_right_x, w_bottom_x, w_left_x;
    always_comb begin
        w_top_x    = '0;
        w_right_x  = '0;
        w_bottom_x = '0;
        w_left_x   = '0;
        w_top_x[NTB-1:0]    = wtop;
        w_right_x[NLR-1:0]  = wright;
        w_bottom_x[NTB-1:0] = wbottom;
        w_left_x[NLR-1:0]   = wleft;
    end

    logic [c_NW-1:0] w_drv_en;
    logic [c_NW-1:0] w_drv_val;

    for (genvar d = 0; d < c_NW; d++) begin : g_route
        logic [2:0]      w_side;
        logic [IDXW-1:0] w_idx;
        assign w_side       = r_active[d][2:0];
        assign w_idx        = r_active[d][c_EW-1:3];
        assign w_drv_en[d]  = (w_side != c_NONE) && !entry_bad(r_active[d], d);
        assign w_drv_val[d] = (w_side == c_TOP)    ? w_top_x[w_idx]    :
                              (w_side == c_RIGHT)  ? w_right_x[w_idx]  :
                              (w_side == c_BOTTOM) ? w_bottom_x[w_idx] :
                              (w_side == c_LEFT)   ? w_left_x[w_idx]   : 1'b0;
    end

    for (genvar t = 0; t < NTB; t++) begin : g_top
        assign wtop[t] = w_drv_en[t] ? w_drv_val[t] : 1'bz;
    end
    for (genvar r = 0; r < NLR; r++) begin : g_right
        assign wright[r] = w_drv_en[NTB + r] ? w_drv_val[NTB + r] : 1'bz;
    end
    for (genvar b = 0; b < NTB; b++) begin : g_bottom
        assign wbottom[b] = w_drv_en[NTB + NLR + b] ? w_drv_val[NTB + NLR + b] : 1'bz;
    end
    for (genvar l = 0; l < NLR; l++) begin : g_left
        assign wleft[l] = w_drv_en[2 * NTB + NLR + l] ? w_drv_val[2 * NTB + NLR + l] : 1'bz;
    end
endmodule

`default_nettype wire

// File: tb/tb_switch_matrix_cfg.sv
// ============================================================================
//  Module   : tb_switch_matrix_cfg
//  Brief    : Directed self-checking bench for switch_matrix_cfg.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_switch_matrix_cfg;
    localparam int NTB  = 5;
    localparam int NLR  = 4;
    localparam int IDXW = 3;
    localparam int NW   = 2 * NTB + 2 * NLR;

    logic clk = 1'b0;
    logic rst_n;

    wire [NTB-1:0] wtop, wbottom;
    wire [NLR-1:0] wleft, wright;

    logic [NTB-1:0] top_en = '0, top_val = '0, bot_en = '0, bot_val = '0;
    logic [NLR-1:0] left_en = '0, left_val = '0, right_en = '0, right_val = '0;

    for (genvar i = 0; i < NTB; i++) begin : g_tb_tb
        assign wtop[i]    = top_en[i] ? top_val[i] : 1'bz;
        assign wbottom[i] = bot_en[i] ? bot_val[i] : 1'bz;
    end
    for (genvar i = 0; i < NLR; i++) begin : g_tb_lr
        assign wleft[i]  = left_en[i] ? left_val[i] : 1'bz;
        assign wright[i] = right_en[i] ? right_val[i] : 1'bz;
    end

    int checks = 0;
    int errors = 0;
    logic [5:0] ent [NW];

    switch_matrix_cfg_if #(.NTB(NTB), .NLR(NLR), .IDXW(IDXW)) cfg_if ();

    switch_matrix_cfg #(.NTB(NTB), .NLR(NLR), .IDXW(IDXW)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wtop    (wtop),
        .wbottom (wbottom),
        .wleft   (wleft),
        .wright  (wright),
        .cfg     (cfg_if.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    task automatic fail(input string tag);
        errors++;
        $error("FAIL %s", tag);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load();
        cfg_if.cfg_start = 1'b1;
        tick();
        cfg_if.cfg_start = 1'b0;
    endtask

    task automatic push(input logic [5:0] w);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_word  = w;
        tick();
        cfg_if.cfg_valid = 1'b0;
    endtask

    task automatic commit();
        cfg_if.cfg_commit = 1'b1;
        tick();
        cfg_if.cfg_commit = 1'b0;
    endtask

    // Pushes all NW entries of ent[]; cfg_err must rise exactly at bad_at (-1: never).
    task automatic load_all(input int bad_at);
        for (int i = 0; i < NW; i++) begin
            push(ent[i]);
            checks++; if (cfg_if.cfg_err !== (bad_at >= 0 && i >= bad_at)) fail("err_during_load");
            checks++; if (cfg_if.cfg_count !== 5'(i + 1)) fail("count_during_load");
        end
        checks++; if (cfg_if.cfg_ready !== 1'b0) fail("ready_when_full");
        checks++; if (cfg_if.cfg_busy !== 1'b1) fail("busy_when_full");
    endtask

    task automatic clear_ent();
        for (int i = 0; i < NW; i++) ent[i] = '0;
    endtask

    initial begin
        rst_n             = 1'b0;
        cfg_if.cfg_start  = 1'b0;
        cfg_if.cfg_valid  = 1'b0;
        cfg_if.cfg_word   = '0;
        cfg_if.cfg_commit = 1'b0;
        cfg_if.cfg_abort  = 1'b0;
        clear_ent();

        // Reset state
        repeat (3) tick();
        checks++; if (wtop !== 5'bzzzzz) fail("rst_wtop");
        checks++; if (wbottom !== 5'bzzzzz) fail("rst_wbottom");
        checks++; if (wleft !== 4'bzzzz) fail("rst_wleft");
        checks++; if (wright !== 4'bzzzz) fail("rst_wright");
        checks++; if ({cfg_if.cfg_ready, cfg_if.cfg_busy, cfg_if.cfg_count, cfg_if.cfg_err, cfg_if.cfg_done} !== 9'b0) fail("rst_status");
        rst_n = 1'b1;
        tick();
        checks++; if ({cfg_if.cfg_ready, cfg_if.cfg_busy, cfg_if.cfg_count, cfg_if.cfg_err, cfg_if.cfg_done} !== 9'b0) fail("post_rst_status");

        // top[0] <- left[2]
        ent[0] = 6'b010_100;
        start_load();
        checks++; if (cfg_if.cfg_ready !== 1'b1) fail("ready_after_start");
        checks++; if (cfg_if.cfg_busy !== 1'b1) fail("busy_after_start");
        checks++; if (cfg_if.cfg_count !== 5'd0) fail("count_after_start");
        load_all(-1);
        push(6'b111_111);
        checks++; if (cfg_if.cfg_count !== 5'd18) fail("valid_ignored_in_full_count");
        checks++; if (cfg_if.cfg_err !== 1'b0) fail("valid_ignored_in_full_err");
        commit();
        checks++; if (cfg_if.cfg_done !== 1'b1) fail("done_after_commit");
        checks++; if (cfg_if.cfg_busy !== 1'b0) fail("idle_after_commit");
        tick();
        checks++; if (cfg_if.cfg_done !== 1'b0) fail("done_one_cycle");
        left_en = 4'b0100; left_val = 4'b0000;
        #1;
        checks++; if (wtop !== 5'bzzzz0) fail("route_l2_0_top");
        checks++; if (wright !== 4'bzzzz) fail("route_l2_0_right");
        checks++; if (wbottom !== 5'bzzzzz) fail("route_l2_0_bottom");
        left_val = 4'b0100;
        #1;
        checks++; if (wtop !== 5'bzzzz1) fail("route_l2_1_top");
        checks++; if (wleft !== 4'bz1zz) fail("route_l2_1_left");

        // Out-of-range index on right[0] poisons the load
        clear_ent();
        ent[5] = 6'b101_010;
        tick();
        start_load();
        load_all(5);
        commit();
        checks++; if (cfg_if.cfg_done !== 1'b0) fail("bad_commit_no_done");
        checks++; if (cfg_if.cfg_err !== 1'b1) fail("bad_commit_err_sticky");
        checks++; if (cfg_if.cfg_busy !== 1'b0) fail("bad_commit_idle");
        tick();
        checks++; if (cfg_if.cfg_done !== 1'b0) fail("bad_commit_no_done_late");
        checks++; if (wtop !== 5'bzzzz1) fail("bad_commit_route_kept");

        // Gapped load then abort
        clear_ent();
        start_load();
        begin
            int acc = 0;
            int cyc = 0;
            while (acc < 7 && cyc < 40) begin
                cfg_if.cfg_valid = (cyc % 2 == 0);
                cfg_if.cfg_word  = '0;
                tick();
                if (cyc % 2 == 0) acc++;
                cyc++;
            end
            cfg_if.cfg_valid = 1'b0;
        end
        checks++; if (cfg_if.cfg_count !== 5'd7) fail("gapped_count");
        cfg_if.cfg_abort = 1'b1;
        tick();
        cfg_if.cfg_abort = 1'b0;
        checks++; if (cfg_if.cfg_busy !== 1'b0) fail("abort_busy");
        checks++; if (cfg_if.cfg_ready !== 1'b0) fail("abort_ready");
        checks++; if (cfg_if.cfg_count !== 5'd7) fail("abort_count_hold");
        commit();
        checks++; if (cfg_if.cfg_done !== 1'b0) fail("commit_in_idle_ignored");
        repeat (2) tick();
        checks++; if (cfg_if.cfg_count !== 5'd7) fail("abort_count_hold_late");
        checks++; if (wtop !== 5'bzzzz1) fail("abort_route_kept");

        // Reset mid-load
        start_load();
        for (int i = 0; i < 10; i++) push(6'b000_000);
        checks++; if (cfg_if.cfg_count !== 5'd10) fail("pre_reset_count");
        rst_n = 1'b0;
        #1;
        checks++; if (wtop !== 5'bzzzzz) fail("reset_wtop_z");
        checks++; if (wleft !== 4'bz1zz) fail("reset_wleft");
        checks++; if ({cfg_if.cfg_ready, cfg_if.cfg_busy, cfg_if.cfg_count, cfg_if.cfg_err, cfg_if.cfg_done} !== 9'b0) fail("reset_status");
        left_en = '0;
        #1;
        rst_n = 1'b1;
        tick();
        // right[1] <- bottom[4], left[3] <- top[2]
        clear_ent();
        ent[6]  = 6'b100_011;
        ent[17] = 6'b010_001;
        start_load();
        load_all(-1);
        commit();
        checks++; if (cfg_if.cfg_done !== 1'b1) fail("reload_done");
        bot_en = 5'b10000; bot_val = 5'b10000;
        top_en = 5'b00100; top_val = 5'b00000;
        #1;
        checks++; if (wright !== 4'bzz1z) fail("reload_right_a");
        checks++; if (wleft !== 4'b0zzz) fail("reload_left_a");
        checks++; if (wtop !== 5'bzz0zz) fail("reload_top_a");
        bot_val = 5'b00000; top_val = 5'b00100;
        #1;
        checks++; if (wright !== 4'bzz0z) fail("reload_right_b");
        checks++; if (wleft !== 4'b1zzz) fail("reload_left_b");
        checks++; if (wbottom !== 5'b0zzzz) fail("reload_bottom_b");
        bot_en = '0; top_en = '0;
        tick();

        // Self-reference, commit in LOAD, restart mid-load
        start_load();
        push(6'b000_001);
        checks++; if (cfg_if.cfg_err !== 1'b1) fail("selfref_err");
        checks++; if (cfg_if.cfg_count !== 5'd1) fail("selfref_count");
        push(6'b000_000);
        commit();
        checks++; if (cfg_if.cfg_busy !== 1'b1) fail("commit_in_load_busy");
        checks++; if (cfg_if.cfg_ready !== 1'b1) fail("commit_in_load_ready");
        checks++; if (cfg_if.cfg_count !== 5'd2) fail("commit_in_load_count");
        checks++; if (cfg_if.cfg_done !== 1'b0) fail("commit_in_load_no_done");
        start_load();
        checks++; if (cfg_if.cfg_err !== 1'b0) fail("restart_err_clear");
        checks++; if (cfg_if.cfg_count !== 5'd0) fail("restart_count_clear");
        checks++; if (cfg_if.cfg_ready !== 1'b1) fail("restart_ready");
        clear_ent();
        load_all(-1);
        commit();
        checks++; if (cfg_if.cfg_done !== 1'b1) fail("clear_done");
        checks++; if (wright !== 4'bzzzz) fail("clear_wright_z");
        checks++; if (wleft !== 4'bzzzz) fail("clear_wleft_z");
        checks++; if (wtop !== 5'bzzzzz) fail("clear_wtop_z");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/switch_matrix_cfg.md
# switch_matrix_cfg

Parametrised, runtime-configurable switch box for the FPGA routing fabric. It has four bidirectional wire sides (top/bottom with NTB wires each, left/right with NLR wires each); every wire is either driven from one other wire or left high-impedance. Routing entries are loaded through a valid/ready word interface into a shadow store and applied atomically on commit. Each entry is validated as it arrives.

## Interface
- NTB, 5: wires on top and on bottom sides
- NLR, 4: wires on left and on right sides
- IDXW, 3: index field width; must satisfy 2^IDXW >= max(NTB,NLR)
- Derived: EW = IDXW+3 (entry width); NW = 2*NTB+2*NLR (entry count)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- wtop, wbottom  inout  NTB  routed wires
- wleft, wright  inout  NLR  routed wires
- cfg_start  in  1  begin/restart a load
- cfg_valid  in  1  cfg_word valid
- cfg_word  in  EW  entry: [EW-1:3] source index, [2:0] source side
- cfg_ready  out  1  entry accepted this cycle when cfg_valid && cfg_ready
- cfg_commit  in  1  apply shadow to active
- cfg_abort  in  1  discard load in progress
- cfg_busy  out  1  load in progress (LOAD or FULL)
- cfg_count  out  clog2(NW+1)  entries accepted in the current load
- cfg_err  out  1  sticky: an invalid entry was accepted
- cfg_done  out  1  one-cycle pulse after a successful commit

## Operation
- Side codes: 1=top, 2=right, 3=bottom, 4=left. Code 0 means the wire is undriven (Z).
- Entry order: top[0..NTB-1], right[0..NLR-1], bottom[0..NTB-1], left[0..NLR-1].
- Each active entry drives its wire from the selected source wire, combinationally.
- An active entry drives Z if any of the following holds:
  - side code is 0 or 5-7;
  - index >= the source side's width;
  - the entry selects its own wire.
- Multi-wire loops are not detected; software must avoid them.
- Invalid entry: side code 5-7, index out of range for its side, or self-reference. Accepting one sets cfg_err. Side code 0 with any index is valid.
- FSM states: IDLE, LOAD, FULL.
  - IDLE: cfg_start goes to LOAD. Entering LOAD sets count=0 and clears cfg_err.
  - LOAD: cfg_ready=1. Each accepted word is written to shadow[count] and count increments. After the NW-th word is accepted, go to FULL. cfg_start restarts (count=0, cfg_err cleared). cfg_abort goes to IDLE.
  - FULL: cfg_ready=0.
    - cfg_commit with cfg_err=0: active <= shadow, go to IDLE, cfg_done pulses.
    - cfg_commit with cfg_err=1: go to IDLE, active unchanged, no cfg_done, cfg_err stays set.
    - cfg_abort: go to IDLE, active unchanged. cfg_start restarts.
- Precedence within a cycle: cfg_abort > cfg_start > cfg_commit > word accept.
- cfg_commit is ignored in IDLE and LOAD. cfg_valid is ignored outside LOAD.
- The active store changes only on a successful commit; routing is never partially updated.

## Timing
- Reset values:
  - active and shadow entries all 0, so every wire is Z;
  - FSM in IDLE;
  - cfg_ready=0, cfg_busy=0, cfg_count=0, cfg_err=0, cfg_done=0.
- Reset asserted mid-load or mid-commit: reset values apply immediately; the load is lost.
- cfg_ready, cfg_busy and cfg_count are registered state decodes.
  - cfg_ready rises the cycle after the cfg_start edge.
  - cfg_ready falls the cycle after the edge that accepts the NW-th word.
- cfg_err is updated at the edge that accepts the invalid word.
- Commit edge: the new routing is visible combinationally immediately after that edge. cfg_done is high for exactly the following cycle.
- Minimum load time: 1 + NW + 1 cycles (start, NW words, commit).
- Gaps in cfg_valid are allowed with no limit.
- Wire propagation has no clocked latency.

## Test plan
- Reset: with external drivers released, all wtop/wbottom/wleft/wright read Z; all status outputs are 0.
- Defaults NTB=5, NLR=4, NW=18. Load entry 0 = 6'b010_100 (top[0] from left[2]), all others 0, then commit:
  - cfg_done pulses once and cfg_err=0;
  - drive wleft[2] with 0 then 1: wtop[0] follows; every other wire stays Z.
- Load with entry 5 (right[0]) = 6'b101_010 (right index 5 >= NLR), then commit: cfg_err=1 on that accept, no cfg_done, previous routing intact.
- Accept 7 words with cfg_valid toggling every other cycle, then assert cfg_abort:
  - cfg_busy=0 and cfg_count holds 7 until the next start;
  - active routing unchanged.
- Assert rst_n low after 10 accepted words: all wires Z immediately, FSM back in IDLE; a subsequent full load and commit succeeds.
- Self-reference and restart:
  - entry 0 = 6'b000_001 (top[0] from top[0]) sets cfg_err;
  - cfg_start mid-load clears cfg_err and count;
  - cfg_commit in LOAD is ignored.
